// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between a CPU data-memory initiator and the
// dmem_responder wait-state memory model.
//   req   initiator -> responder  request, held high until ack
//   wmem  initiator -> responder  1 = write, 0 = read
//   addr  initiator -> responder  32-bit byte address
//   data  initiator -> responder  32-bit write data
//   mem   responder -> initiator  read data, valid only with ack
//   ack   responder -> initiator  one-cycle response strobe
//   err   responder -> initiator  misaligned-address flag, valid only with ack
//   busy  responder -> initiator  transaction in flight
// ---------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req;
    logic        wmem;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mem;
    logic        ack;
    logic        err;
    logic        busy;

    modport master (
        output req, wmem, addr, data,
        input  mem, ack, err, busy
    );

    modport slave (
        input  req, wmem, addr, data,
        output mem, ack, err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Word-addressed data memory (2**AW x 32) with a fixed number of wait states
// between accepting a request and strobing the response.
//   clk   single clock, rising edge
//   clrn  asynchronous active-low reset; clears FSM, outputs and storage
//   bus   dmem_responder_if.slave (req/wmem/addr/data in, mem/ack/err/busy out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready; a high req is accepted on the next rising edge
// WAITING | wait-state countdown, exactly WAIT cycles
// RESP    | ack high for one cycle with mem/err
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int AW   = 6,
    parameter int WAIT = 2
) (
    input  logic            clk,
    input  logic            clrn,
    dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAITING, RESP} state_t;

    localparam int         DEPTH    = 1 << AW;
    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t          state;
    logic [3:0]      cnt;
    logic            lat_wmem;
    logic            lat_mis;
    logic [AW-1:0]   lat_idx;
    logic [31:0]     lat_data;
    logic [31:0]     store [0:DEPTH-1];

    logic            accept;
    logic            enter_resp;
    logic            use_wmem;
    logic            use_mis;
    logic [AW-1:0]   use_idx;
    logic [31:0]     use_data;
    logic            write_en;

    // Upper address bits fold onto the same words (wrap-around).
    logic            unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.addr[31:AW+2]};

    // With WAIT = 0 the response is set up on the accept edge itself, so the
    // live bus values stand in for the not-yet-latched copies.
    always_comb begin
        accept     = (state == IDLE) && bus.req;
        enter_resp = (accept && (WAIT == 0)) || ((state == WAITING) && (cnt == 4'd0));
        if (state == IDLE) begin
            use_wmem = bus.wmem;
            use_mis  = |bus.addr[1:0];
            use_idx  = bus.addr[AW+1:2];
            use_data = bus.data;
        end else begin
            use_wmem = lat_wmem;
            use_mis  = lat_mis;
            use_idx  = lat_idx;
            use_data = lat_data;
        end
        write_en = enter_resp && use_wmem && !use_mis;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            lat_wmem <= 1'b0;
            lat_mis  <= 1'b0;
            lat_idx  <= '0;
            lat_data <= 32'd0;
            bus.ack  <= 1'b0;
            bus.err  <= 1'b0;
            bus.mem  <= 32'd0;
            bus.busy <= 1'b0;
        end else begin
            bus.ack <= 1'b0;
            bus.err <= 1'b0;
            bus.mem <= 32'd0;
            case (state)
                IDLE: begin
                    bus.busy <= accept;
                    if (accept) begin
                        lat_wmem <= bus.wmem;
                        lat_mis  <= |bus.addr[1:0];
                        lat_idx  <= bus.addr[AW+1:2];
                        lat_data <= bus.data;
                        if (WAIT == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAITING;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAITING: begin
                    bus.busy <= 1'b1;
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
            // Read data is the word as it stands on the edge entering RESP,
            // so a write committed by the previous transaction is visible.
            if (enter_resp) begin
                bus.ack <= 1'b1;
                bus.err <= use_mis;
                bus.mem <= (use_mis || use_wmem) ? 32'd0 : store[use_idx];
            end
        end
    end

    // Writes commit only on the edge entering RESP; an aborted transaction
    // never touches storage.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) store[i] <= 32'd0;
        end else if (write_en) begin
            store[use_idx] <= use_data;
        end
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter AW, default 6, meaning log2 of word depth (64 x 32-bit words).
REQ-002 SHALL have parameter WAIT, default 2, meaning wait-state cycles between accept and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  1  initiator request; held high until ack.
REQ-006 SHALL have port wmem  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr  input  32  byte address from CPU ALU result.
REQ-008 SHALL have port data  input  32  write data.
REQ-009 SHALL have port mem  output  32  read data; valid only while ack = 1.
REQ-010 SHALL have port ack  output  1  one-cycle response strobe.
REQ-011 SHALL have port err  output  1  misalignment flag; valid only while ack = 1.
REQ-012 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WAITING, RESP.
REQ-014 SHALL, in IDLE with req = 1, accept: latch wmem, addr, data; go to WAITING with wait counter = WAIT-1 if WAIT > 0, else go directly to RESP.
REQ-015 SHALL, in WAITING, decrement counter each cycle; enter RESP the cycle after counter reaches 0 (exactly WAIT cycles in WAITING).
REQ-016 SHALL, in RESP, drive ack = 1 for exactly one cycle, then return to IDLE.
REQ-017 SHALL ignore req outside IDLE; changes to addr/data/wmem after accept have no effect.
REQ-018 SHALL treat req still high in the IDLE cycle after ack as a new request (initiator deasserts on ack); max throughput one transaction per WAIT+2 cycles.
REQ-019 SHALL index storage by latched addr[AW+1:2]; upper address bits ignored (wrap-around modulo 2^AW words).
REQ-020 SHALL flag err = 1 with ack when latched addr[1:0] != 0; write suppressed, mem = 0.
REQ-021 SHALL commit an aligned write on the clock edge entering RESP; mem = 0 during a write response.
REQ-022 SHALL drive mem, for an aligned read, with word contents as of the edge entering RESP, including a write completed in the immediately preceding transaction.
REQ-023 SHALL drive mem = 0, ack = 0, err = 0 whenever ack is not asserted.
REQ-024 SHALL keep busy = 1 in WAITING and RESP, 0 in IDLE.

Reset
REQ-025 SHALL, on clrn = 0, immediately force state IDLE, counter 0, ack = 0, err = 0, busy = 0, mem = 0, all storage words 0.
REQ-026 SHALL abort an in-flight transaction on reset; a write not yet committed per REQ-021 SHALL NOT modify storage.
REQ-027 SHALL not accept req in the cycle clrn is low; first accept is possible on the first rising edge with clrn = 1.

Verification
REQ-028 SHALL verify write/read: WAIT=2, write addr 0x10 data 0xDEADBEEF, then read 0x10 -> ack 3 cycles after each accept edge, read mem = 0xDEADBEEF, err = 0.
REQ-029 SHALL verify misalignment: write 0x12 data 0x1 -> ack with err = 1; subsequent read 0x10 returns previous value, err = 0.
REQ-030 SHALL verify wrap-around: AW=6, write 0x100 data 0xA5A5A5A5, read 0x000 -> mem = 0xA5A5A5A5.
REQ-031 SHALL verify WAIT=0: accept edge followed by ack next cycle; back-to-back requests complete every 2 cycles; busy pattern 1,0 repeating.
REQ-032 SHALL verify reset mid-operation: accept write 0x20 data 0x55, pull clrn low in WAITING -> ack never asserted, busy = 0 at once; read 0x20 after release returns 0.
REQ-033 SHALL verify protocol invariants throughout: ack exactly one cycle per accept, never without prior accept; mem/err = 0 when ack = 0.
